// File: rtl/i2s_dac_tx_if.sv
// rtl/i2s_dac_tx_if.sv - sample-pair handshake between upstream source and the I2S transmitter
interface i2s_dac_tx_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] data_l;
    logic [DATA_W-1:0] data_r;
    logic              sample_valid;
    logic              sample_rdy;
    logic              sample_req;

    modport master (
        output data_l,
        output data_r,
        output sample_valid,
        input  sample_rdy,
        input  sample_req
    );

    modport slave (
        input  data_l,
        input  data_r,
        input  sample_valid,
        output sample_rdy,
        output sample_req
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S / left-justified stereo DAC serializer with frame-paced sample handshake
module i2s_dac_tx #(
    parameter int DATA_W    = 24,
    parameter int SLOT_W    = 32,
    parameter int SCLK_HALF = 2,
    parameter int MCLK_HALF = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fmt,
    input  logic         mute,
    input  logic         underrun_clr,
    output logic         underrun,
    output logic         mclk_dac,
    output logic         sclk_dac,
    output logic         lrck_dac,
    output logic         sdata_dac,
    i2s_dac_tx_if.slave  smp
);
    localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int MCK_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int BC_W  = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [MCK_W-1:0] MCK_LAST = MCK_W'(MCLK_HALF - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SLOT_W - 1);
    localparam logic [BC_W-1:0]  SLOT_V   = BC_W'(SLOT_W);

    logic [MCK_W-1:0]  mclk_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shift_l;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              fresh;
    logic              fmt_q;
    logic              prev_bit;

    logic              shift_ev;
    logic              frame_start;
    logic              capture;
    logic [BC_W-1:0]   nxt_bit_cnt;
    logic [DATA_W-1:0] nxt_l;
    logic [DATA_W-1:0] nxt_r;
    logic [DATA_W-1:0] word;
    logic [BC_W-1:0]   slot_k;
    logic              nxt_fmt;
    logic              in_right;
    logic              lj_bit;
    logic              sdata_nxt;

    assign shift_ev    = sclk_dac && (div_cnt == DIV_LAST);
    assign frame_start = shift_ev && (bit_cnt == BC_LAST);
    assign capture     = smp.sample_valid && smp.sample_rdy;

    // Everything below is evaluated for the bit position about to be driven,
    // so the frame-start load is visible to the very first bit of the frame.
    always_comb begin
        nxt_bit_cnt = frame_start ? '0 : bit_cnt + 1'b1;
        nxt_l       = shift_l;
        nxt_r       = shift_r;
        if (frame_start) begin
            nxt_l = mute ? '0 : hold_l;
            nxt_r = mute ? '0 : hold_r;
        end
        nxt_fmt  = frame_start ? fmt : fmt_q;
        in_right = (nxt_bit_cnt >= SLOT_V);
        slot_k   = in_right ? (nxt_bit_cnt - SLOT_V) : nxt_bit_cnt;
        word     = in_right ? nxt_r : nxt_l;
        lj_bit   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (slot_k == BC_W'(DATA_W - 1 - i)) begin
                lj_bit = word[i];
            end
        end
        // I2S is the left-justified stream delayed by one sclk, spilling across frames.
        sdata_nxt = nxt_fmt ? lj_bit : prev_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mclk_cnt <= '0;
            mclk_dac <= 1'b0;
        end else if (mclk_cnt == MCK_LAST) begin
            mclk_cnt <= '0;
            mclk_dac <= ~mclk_dac;
        end else begin
            mclk_cnt <= mclk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            sclk_dac <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sclk_dac <= ~sclk_dac;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            lrck_dac  <= 1'b0;
            sdata_dac <= 1'b0;
            prev_bit  <= 1'b0;
            shift_l   <= '0;
            shift_r   <= '0;
            fmt_q     <= 1'b0;
        end else if (shift_ev) begin
            bit_cnt   <= nxt_bit_cnt;
            lrck_dac  <= in_right;
            sdata_dac <= sdata_nxt;
            prev_bit  <= lj_bit;
            shift_l   <= nxt_l;
            shift_r   <= nxt_r;
            fmt_q     <= nxt_fmt;
        end
    end

    // A pair captured on the frame-start cycle is on time for the next frame,
    // so it suppresses the underrun even though the old pair is what gets loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp.sample_req <= 1'b0;
            smp.sample_rdy <= 1'b0;
            hold_l         <= '0;
            hold_r         <= '0;
            fresh          <= 1'b1;
            underrun       <= 1'b0;
        end else begin
            smp.sample_req <= frame_start;
            if (frame_start) begin
                smp.sample_rdy <= 1'b1;
            end else if (capture) begin
                smp.sample_rdy <= 1'b0;
            end
            if (capture) begin
                hold_l <= smp.data_l;
                hold_r <= smp.data_r;
                fresh  <= 1'b1;
            end else if (frame_start) begin
                fresh <= 1'b0;
            end
            if (frame_start && !fresh && !capture) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - randomized self-checking bench for i2s_dac_tx against a frame-level model
module tb_i2s_dac_tx;
    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int SCLK_HALF = 2;
    localparam int MCLK_HALF = 1;
    localparam int FRAME     = 2 * SCLK_HALF * 2 * SLOT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fmt = 1'b0;
    logic mute = 1'b0;
    logic underrun_clr = 1'b0;
    logic underrun, mclk_dac, sclk_dac, lrck_dac, sdata_dac;

    i2s_dac_tx_if #(.DATA_W(DATA_W)) smp ();

    i2s_dac_tx #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .SCLK_HALF(SCLK_HALF), .MCLK_HALF(MCLK_HALF)
    ) dut (
        .clk(clk), .rst(rst), .fmt(fmt), .mute(mute), .underrun_clr(underrun_clr),
        .underrun(underrun), .mclk_dac(mclk_dac), .sclk_dac(sclk_dac),
        .lrck_dac(lrck_dac), .sdata_dac(sdata_dac), .smp(smp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int                cyc;
    logic [DATA_W-1:0] hold_l_m, hold_r_m;
    bit                fresh_m, rdy_m, und_m;
    logic [DATA_W-1:0] fl [0:31];
    logic [DATA_W-1:0] fr [0:31];
    bit                ff [0:31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Left-justified slot content: bit n of frame f.
    function automatic logic lj(input int f, input int n);
        logic [DATA_W-1:0] w;
        int k;
        w = (n < SLOT_W) ? fl[f] : fr[f];
        k = n % SLOT_W;
        if (k < DATA_W) return w[DATA_W-1-k];
        return 1'b0;
    endfunction

    function automatic logic exp_bit(input int f, input int n);
        if (ff[f]) return lj(f, n);
        if (n > 0) return lj(f, n - 1);
        if (f > 0) return lj(f - 1, 2 * SLOT_W - 1);
        return 1'b0;
    endfunction

    task automatic model_reset();
        cyc = 0;
        hold_l_m = '0;
        hold_r_m = '0;
        fresh_m = 1'b1;
        rdy_m = 1'b0;
        und_m = 1'b0;
        fl[0] = '0;
        fr[0] = '0;
        ff[0] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mclk"}, {31'd0, mclk_dac}, 32'd0);
        check({tag, "_sclk"}, {31'd0, sclk_dac}, 32'd0);
        check({tag, "_lrck"}, {31'd0, lrck_dac}, 32'd0);
        check({tag, "_sdata"}, {31'd0, sdata_dac}, 32'd0);
        check({tag, "_req"}, {31'd0, smp.sample_req}, 32'd0);
        check({tag, "_rdy"}, {31'd0, smp.sample_rdy}, 32'd0);
        check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    task automatic step();
        bit cap, fs;
        int f, j, bc;
        @(posedge clk);
        cyc++;
        cap = smp.sample_valid && rdy_m;
        fs  = (cyc % FRAME) == 0;
        if (fs) begin
            f = cyc / FRAME;
            fl[f] = mute ? '0 : hold_l_m;
            fr[f] = mute ? '0 : hold_r_m;
            ff[f] = fmt;
        end
        if (fs && !fresh_m && !cap) und_m = 1'b1;
        else if (underrun_clr) und_m = 1'b0;
        if (cap) begin
            hold_l_m = smp.data_l;
            hold_r_m = smp.data_r;
            fresh_m = 1'b1;
        end else if (fs) begin
            fresh_m = 1'b0;
        end
        if (fs) rdy_m = 1'b1;
        else if (cap) rdy_m = 1'b0;
        #1;
        bc = (cyc / (2 * SCLK_HALF)) % (2 * SLOT_W);
        check("sample_req", {31'd0, smp.sample_req}, {31'd0, fs});
        check("sample_rdy", {31'd0, smp.sample_rdy}, {31'd0, rdy_m});
        check("underrun", {31'd0, underrun}, {31'd0, und_m});
        check("sclk", {31'd0, sclk_dac}, 32'((cyc / SCLK_HALF) % 2));
        check("mclk", {31'd0, mclk_dac}, 32'((cyc / MCLK_HALF) % 2));
        check("lrck", {31'd0, lrck_dac}, {31'd0, bc >= SLOT_W});
        if ((cyc % (2 * SCLK_HALF)) == SCLK_HALF) begin
            j = cyc / (2 * SCLK_HALF);
            check("sdata", {31'd0, sdata_dac},
                  {31'd0, exp_bit(j / (2 * SLOT_W), j % (2 * SLOT_W))});
        end
    endtask

    // scen: 0 = capture mid-frame, 1 = no capture, 2 = valid on the closing frame-start cycle.
    task automatic run_frame(input int scen, input bit fmt_s, input bit mute_s, input bit do_clr,
                             input logic [DATA_W-1:0] dl, input logic [DATA_W-1:0] dr);
        int off, clr_off;
        off = $urandom_range(5, FRAME - 10);
        clr_off = $urandom_range(1, FRAME - 1);
        for (int c = 1; c <= FRAME; c++) begin
            smp.sample_valid = (scen == 0 && c == off) || (scen == 2 && c == FRAME);
            smp.data_l = smp.sample_valid ? dl : DATA_W'($urandom);
            smp.data_r = smp.sample_valid ? dr : DATA_W'($urandom);
            fmt  = (c == FRAME) ? fmt_s : 1'($urandom);
            mute = (c == FRAME) ? mute_s : 1'($urandom);
            underrun_clr = do_clr && (c == clr_off);
            step();
        end
        smp.sample_valid = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin
        smp.sample_valid = 1'b0;
        smp.data_l = '0;
        smp.data_r = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        run_frame(1, 1'b1, 1'b0, 1'b0, '0, '0);
        run_frame(0, 1'b1, 1'b0, 1'b0, 24'hA5A5A5, 24'h123456);
        run_frame(0, 1'b0, 1'b0, 1'b0, 24'hA5A5A5, 24'h123456);
        run_frame(1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(1, 1'b1, 1'b0, 1'b1, '0, '0);
        run_frame(2, 1'b1, 1'b0, 1'b0, 24'h0F1E2D, 24'hC3B4A5);
        run_frame(1, 1'b1, 1'b0, 1'b0, '0, '0);
        run_frame(0, 1'b1, 1'b1, 1'b0, 24'h7FFFFF, 24'h800001);
        for (int f = 8; f < 16; f++) begin
            run_frame(int'($urandom % 3), 1'($urandom), ($urandom % 4) == 0, 1'($urandom),
                      DATA_W'($urandom), DATA_W'($urandom));
        end

        // Abort a frame in the right slot after capturing a pair that must be discarded.
        for (int c = 1; c <= 40 * 2 * SCLK_HALF; c++) begin
            smp.sample_valid = (c == 50);
            smp.data_l = DATA_W'($urandom);
            smp.data_r = DATA_W'($urandom);
            step();
        end
        smp.sample_valid = 1'b0;
        check("pre_reset_lrck", {31'd0, lrck_dac}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        rst = 1'b1;
        model_reset();
        run_frame(1, 1'b1, 1'b0, 1'b0, '0, '0);
        run_frame(0, 1'b1, 1'b0, 1'b0, 24'h5A5A5A, 24'hFEDCBA);
        run_frame(1, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 Parameter DATA_W, default 24: sample width per channel in bits; legal range 16..SLOT_W.
REQ-002 Parameter SLOT_W, default 32: sclk bits per channel slot; legal range 16..32.
REQ-003 Parameter SCLK_HALF, default 2: clk cycles per sclk half-period; must be at least 1.
REQ-004 Parameter MCLK_HALF, default 1: clk cycles per mclk half-period; must be at least 1.
REQ-005 Port clk, input, 1 bit: single clock (6.5536 MHz PLL output); all logic SHALL run on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port fmt, input, 1 bit: frame format; 0 = I2S (MSB one sclk after the lrck edge), 1 = left-justified (MSB on the lrck edge).
REQ-008 Port mute, input, 1 bit: force zero output data.
REQ-009 Port data_l / data_r, input, DATA_W bits each: left and right samples, two's complement.
REQ-010 Port sample_valid, input, 1 bit: upstream presents data_l and data_r.
REQ-011 Port sample_rdy, output, 1 bit: block accepts a sample pair.
REQ-012 Port sample_req, output, 1 bit: one-clk pulse at each frame start.
REQ-013 Port underrun, output, 1 bit: sticky flag, set when a frame starts with no new sample captured.
REQ-014 Port underrun_clr, input, 1 bit: synchronous clear of underrun.
REQ-015 Port mclk_dac, sclk_dac, lrck_dac, sdata_dac, outputs, 1 bit each: DAC serial interface.

Function
REQ-016 mclk_dac SHALL toggle every MCLK_HALF clk cycles, free-running, driven by its own counter.
REQ-017 Divider div_cnt SHALL count 0..SCLK_HALF-1; at terminal count sclk_dac toggles and div_cnt wraps to 0.
REQ-018 A "shift event" SHALL be the clk cycle in which sclk_dac toggles 1->0; sdata_dac and lrck_dac change only on shift events, so the DAC samples on the sclk rising edge.
REQ-019 bit_cnt (width clog2(2*SLOT_W)) SHALL advance on each shift event, wrapping from 2*SLOT_W-1 to 0; lrck_dac = 0 for bit_cnt < SLOT_W (left slot) and 1 otherwise.
REQ-020 Frame start SHALL be the shift event at which bit_cnt wraps to 0; at that event shift_l/shift_r load from hold_l/hold_r, or load zeros if mute=1 at that cycle.
REQ-021 fmt=1: slot bit k (k = bit_cnt mod SLOT_W) SHALL carry sample bit DATA_W-1-k for k < DATA_W and 0 otherwise.
REQ-022 fmt=0: the same mapping SHALL apply, delayed by one shift event; the LSB of the right slot spills into bit_cnt 0 of the next frame, i.e. the bit transmitted there is the previous frame's right-channel LSB, not the new frame's left MSB.
REQ-023 fmt SHALL be sampled only at frame start; a mid-frame change SHALL take effect from the next frame.
REQ-024 sample_req SHALL be high for exactly the one clk cycle following frame start.
REQ-025 sample_rdy SHALL rise together with sample_req and fall on the cycle after a capture (sample_valid & sample_rdy), or at the next frame start, whichever comes first.
REQ-026 On capture, hold_l and hold_r SHALL register data_l and data_r, and a "fresh" flag SHALL be set.
REQ-027 At frame start, if fresh=0, underrun SHALL set and the previous hold values SHALL replay; fresh SHALL then clear.
REQ-028 If capture and frame start occur in the same cycle, frame start SHALL use the old hold values, and the captured pair SHALL count for the next frame.
REQ-029 underrun_clr SHALL clear underrun unless a set occurs in the same cycle; set wins.
REQ-030 With defaults, the sclk period SHALL be 4 clk, the frame 256 clk, and lrck 25.6 kHz.

Reset
REQ-031 While rst=0: all counters and shift/hold registers = 0; mclk_dac, sclk_dac, lrck_dac, sdata_dac, sample_req, sample_rdy, underrun = 0; fresh = 1.
REQ-032 After release, the first frame SHALL transmit zeros with no underrun; the first sample_req SHALL occur at the first frame start.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately and discard any captured sample.

Verification
REQ-034 Defaults, fmt=1; capture data_l=24'hA5A5A5, data_r=24'h123456 after the first sample_req -> next frame left slot bits 0..23 = A5A5A5 MSB-first, bits 24..31 = 0; right slot = 123456.
REQ-035 Same data, fmt=0 -> every bit delayed one sclk; bit_cnt 0 of the following frame carries right LSB = 0.
REQ-036 sample_valid held 0 for two frames after data loaded -> underrun=1 at the next frame start, same samples replayed; pulse underrun_clr -> underrun=0.
REQ-037 mute=1 during a frame -> that frame still outputs data; the next frame outputs all zeros while lrck and sclk keep running.
REQ-038 sample_valid asserted exactly on the frame-start cycle -> old data sent; new data sent the following frame; no underrun.
REQ-039 rst pulsed low at bit_cnt=40 -> all outputs 0 asynchronously; after release, the first sample_req occurs 256 clk later.
